// File: rtl/iddmm_result_drain.sv
// iddmm_result_drain: captures the IDDMM final result and its "minus p" twin, picks the
// reduced one by cal_sign and replays it LSW-first on a valid/ready stream.
// Optional feature: define IDDMM_DRAIN_FLUSH_EN to add a synchronous flush input.
module iddmm_result_drain #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
`ifdef IDDMM_DRAIN_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         fifo_wr_en_a,
    input  logic [K-1:0] fifo_wr_data_a,
    input  logic         fifo_wr_en_sub,
    input  logic [K-1:0] fifo_wr_data_sub,
    input  logic         cal_done,
    input  logic         cal_sign,
    output logic         res_valid,
    output logic [K-1:0] res_data,
    output logic         res_last,
    input  logic         res_ready,
    output logic         busy,
    output logic         sel_a,
    output logic         err
);
    typedef enum logic [1:0] {COLLECT, SELECT, STREAM} state_t;

    localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0] LASTW = (ADDR_W+1)'(N-1);

    state_t              state;
    logic [ADDR_W:0]     wa, ws, rd_ptr;
    logic                done_seen, rv, rl, sk_v, sk_l;
    logic [K-1:0]        rq, sk_d;
    logic [K-1:0]        buf_a [N];
    logic [K-1:0]        buf_s [N];
    logic                fl, col, wr_a, wr_s, bad, go, fire, rd_en, load;
    logic [1:0]          occ;
    logic [ADDR_W-1:0]   ra;

`ifdef IDDMM_DRAIN_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif

    // Push acceptance, error detection and read issue; reads are only issued when the
    // output register plus skid can absorb the word arriving one cycle later.
    always_comb begin
        col   = state == COLLECT;
        wr_a  = fifo_wr_en_a && col && wa != FULL && !fl;
        wr_s  = fifo_wr_en_sub && col && ws != FULL && !fl;
        bad   = (!fl && ((fifo_wr_en_a && !wr_a) || (fifo_wr_en_sub && !wr_s)))
              || (cal_done && (!col || done_seen));
        go    = col && wa == FULL && ws == FULL && (done_seen || cal_done);
        fire  = res_valid && res_ready;
        occ   = 2'(res_valid) + 2'(sk_v) + 2'(rv);
        rd_en = !fl && (state == SELECT
              || (state == STREAM && rd_ptr != FULL && occ < 2'd2 + 2'(fire)));
        ra    = state == SELECT ? '0 : rd_ptr[ADDR_W-1:0];
        load  = !res_valid || res_ready;
    end

    // Result buffers with one-cycle synchronous read; contents need no reset.
    always_ff @(posedge clk) begin
        if (wr_a) buf_a[wa[ADDR_W-1:0]] <= fifo_wr_data_a;
        if (wr_s) buf_s[ws[ADDR_W-1:0]] <= fifo_wr_data_sub;
        if (rd_en) rq <= sel_a ? buf_a[ra] : buf_s[ra];
    end

    // Collect/select/stream control with output register and one-entry skid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            wa        <= '0;
            ws        <= '0;
            rd_ptr    <= '0;
            done_seen <= 1'b0;
            rv        <= 1'b0;
            rl        <= 1'b0;
            sk_v      <= 1'b0;
            sk_l      <= 1'b0;
            sk_d      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_last  <= 1'b0;
            busy      <= 1'b0;
            sel_a     <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (wr_a) wa <= wa + 1'b1;
            if (wr_s) begin
                ws <= ws + 1'b1;
                if (ws == LASTW) sel_a <= cal_sign;
            end
            if (cal_done && col) done_seen <= 1'b1;
            if (bad) err <= 1'b1;
            rv <= rd_en;
            if (rd_en) begin
                rl <= state == STREAM && rd_ptr == LASTW;
                if (state == STREAM) rd_ptr <= rd_ptr + 1'b1;
            end
            if (load) begin
                if (sk_v) begin
                    res_valid <= 1'b1;
                    res_data  <= sk_d;
                    res_last  <= sk_l;
                    sk_v      <= rv;
                    sk_d      <= rq;
                    sk_l      <= rl;
                end else begin
                    res_valid <= rv;
                    if (rv) begin
                        res_data <= rq;
                        res_last <= rl;
                    end
                end
            end else if (rv) begin
                sk_v <= 1'b1;
                sk_d <= rq;
                sk_l <= rl;
            end
            if (state == COLLECT && go) begin
                state <= SELECT;
                busy  <= 1'b1;
            end
            if (state == SELECT) begin
                state  <= STREAM;
                rd_ptr <= (ADDR_W+1)'(1);
            end
            if (fl || (state == STREAM && fire && res_last)) begin
                state     <= COLLECT;
                busy      <= 1'b0;
                wa        <= '0;
                ws        <= '0;
                rd_ptr    <= '0;
                done_seen <= 1'b0;
                res_valid <= 1'b0;
                res_last  <= 1'b0;
                sk_v      <= 1'b0;
                rv        <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_iddmm_result_drain.sv
// tb_iddmm_result_drain: randomized self-checking bench for iddmm_result_drain.
module tb_iddmm_result_drain;
    localparam int K = 128;
    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst;
`ifdef IDDMM_DRAIN_FLUSH_EN
    logic         flush;
`endif
    logic         fifo_wr_en_a, fifo_wr_en_sub, cal_done, cal_sign, res_ready;
    logic [K-1:0] fifo_wr_data_a, fifo_wr_data_sub, res_data;
    logic         res_valid, res_last, busy, sel_a, err;

    int           passed = 0;
    int           total = 0;
    logic [K-1:0] a_w [N];
    logic [K-1:0] s_w [N];
    logic [K-1:0] got [$];
    int           lastpos, nlast, stall_bad;
    bit           timeout;
    logic         busy_after, valid_after;

    iddmm_result_drain #(.K(K), .N(N)) dut (
        .clk(clk), .rst(rst),
`ifdef IDDMM_DRAIN_FLUSH_EN
        .flush(flush),
`endif
        .fifo_wr_en_a(fifo_wr_en_a), .fifo_wr_data_a(fifo_wr_data_a),
        .fifo_wr_en_sub(fifo_wr_en_sub), .fifo_wr_data_sub(fifo_wr_data_sub),
        .cal_done(cal_done), .cal_sign(cal_sign),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready),
        .busy(busy), .sel_a(sel_a), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the reduced result is the unreduced words when the subtraction borrowed.
    function automatic logic [K-1:0] ref_word(input bit sign, input int i);
        return sign ? a_w[i] : s_w[i];
    endfunction

    task automatic gen(input bit rnd);
        for (int i = 0; i < N; i++) begin
            a_w[i] = rnd ? {$urandom, $urandom, $urandom, $urandom} : K'(i + 1);
            s_w[i] = rnd ? {$urandom, $urandom, $urandom, $urandom} : K'(32'h100 + i);
        end
    endtask

    task automatic load(input bit sign, input int extra_a);
        cal_sign = sign;
        for (int i = 0; i < N + extra_a; i++) begin
            fifo_wr_en_a     = 1'b1;
            fifo_wr_data_a   = i < N ? a_w[i] : '1;
            fifo_wr_en_sub   = i < N;
            fifo_wr_data_sub = i < N ? s_w[i] : '0;
            cal_done         = i == N - 2;
            tick;
        end
        fifo_wr_en_a   = 1'b0;
        fifo_wr_en_sub = 1'b0;
        cal_done       = 1'b0;
    endtask

    task automatic drain(input int mode);
        bit           hold, done, r;
        logic [K-1:0] hd;
        logic         hl;
        got.delete();
        lastpos = -1; nlast = 0; stall_bad = 0; timeout = 1'b1; hold = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (hold && (!res_valid || res_data !== hd || res_last !== hl)) stall_bad++;
            r = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
            res_ready = r;
            hold = res_valid && !r; hd = res_data; hl = res_last;
            done = res_valid && r && res_last;
            if (res_valid && r) begin
                got.push_back(res_data);
                if (res_last) begin lastpos = got.size() - 1; nlast++; end
            end
            tick;
            if (done) begin
                busy_after = busy; valid_after = res_valid; timeout = 1'b0;
                res_ready = 1'b1;
                return;
            end
        end
        res_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        total++; if (res_valid !== 1'b0) $display("FAIL reset res_valid: got %b want 0", res_valid); else passed++;
        total++; if (res_data !== '0) $display("FAIL reset res_data: got %h want 0", res_data); else passed++;
        total++; if (res_last !== 1'b0) $display("FAIL reset res_last: got %b want 0", res_last); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passed++;
        total++; if (sel_a !== 1'b0) $display("FAIL reset sel_a: got %b want 0", sel_a); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset err: got %b want 0", err); else passed++;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_stream(input string name, input bit sign, input int mode, input bit rnd,
                               input int extra_a, input bit exp_err);
        gen(rnd);
        res_ready = 1'b1;
        load(sign, extra_a);
        total++; if (err !== exp_err) $display("FAIL %s err after load: got %b want %b", name, err, exp_err); else passed++;
        if (extra_a == 0) begin
            total++; if (busy !== 1'b0 || res_valid !== 1'b0) $display("FAIL %s t+0 busy/valid: got %b%b want 00", name, busy, res_valid); else passed++;
            tick;
            total++; if (busy !== 1'b1) $display("FAIL %s t+1 busy: got %b want 1", name, busy); else passed++;
            tick;
            total++; if (res_valid !== 1'b0) $display("FAIL %s t+2 res_valid: got %b want 0", name, res_valid); else passed++;
            tick;
            total++; if (res_valid !== 1'b1) $display("FAIL %s t+3 res_valid: got %b want 1", name, res_valid); else passed++;
        end
        drain(mode);
        total++; if (timeout !== 1'b0) $display("FAIL %s drain timeout: got %b want 0", name, timeout); else passed++;
        total++; if (got.size() !== N) $display("FAIL %s beat count: got %0d want %0d", name, got.size(), N); else passed++;
        for (int i = 0; i < N && i < got.size(); i++) begin
            total++; if (got[i] !== ref_word(sign, i)) $display("FAIL %s beat %0d: got %h want %h", name, i, got[i], ref_word(sign, i)); else passed++;
        end
        total++; if (lastpos !== N - 1 || nlast !== 1) $display("FAIL %s res_last: got pos %0d count %0d want pos %0d count 1", name, lastpos, nlast, N - 1); else passed++;
        total++; if (stall_bad !== 0) $display("FAIL %s stall stability: got %0d unstable cycles want 0", name, stall_bad); else passed++;
        total++; if (busy_after !== 1'b0 || valid_after !== 1'b0) $display("FAIL %s after last busy/valid: got %b%b want 00", name, busy_after, valid_after); else passed++;
        total++; if (sel_a !== sign) $display("FAIL %s sel_a: got %b want %b", name, sel_a, sign); else passed++;
        total++; if (err !== exp_err) $display("FAIL %s err after drain: got %b want %b", name, err, exp_err); else passed++;
        tick;
    endtask

    task automatic test_overflow;
        test_stream("overflow", 1'b1, 0, 1'b1, 1, 1'b1);
    endtask

    task automatic test_rst_mid;
        int cnt;
        bit hit;
        gen(1'b1);
        res_ready = 1'b1;
        load(1'b0, 0);
        cnt = 0; hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (res_valid && cnt == 10) hit = 1'b1;
            else begin
                if (res_valid) cnt++;
                tick;
            end
        end
        total++; if (hit !== 1'b1) $display("FAIL rst_mid reach beat 10: got %b want 1", hit); else passed++;
        rst = 1'b1;
        #1;
        total++; if (res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid async clear valid/busy: got %b%b want 00", res_valid, busy); else passed++;
        tick;
        rst = 1'b0;
        tick;
        test_stream("after_rst", 1'b1, 2, 1'b1, 0, 1'b0);
    endtask

`ifdef IDDMM_DRAIN_FLUSH_EN
    task automatic test_flush;
        int cnt;
        bit hit;
        gen(1'b0);
        res_ready = 1'b1;
        load(1'b1, 0);
        cnt = 0; hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (res_valid && cnt == 5) hit = 1'b1;
            else begin
                if (res_valid) cnt++;
                tick;
            end
        end
        total++; if (hit !== 1'b1) $display("FAIL flush reach beat 5: got %b want 1", hit); else passed++;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        total++; if (res_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) $display("FAIL flush valid/busy/err: got %b%b%b want 000", res_valid, busy, err); else passed++;
        tick;
        test_stream("after_flush", 1'b0, 1, 1'b1, 0, 1'b0);
    endtask
`endif

    initial begin
        rst = 1'b1;
`ifdef IDDMM_DRAIN_FLUSH_EN
        flush = 1'b0;
`endif
        fifo_wr_en_a = 1'b0; fifo_wr_en_sub = 1'b0; cal_done = 1'b0; cal_sign = 1'b0;
        fifo_wr_data_a = '0; fifo_wr_data_sub = '0; res_ready = 1'b1;
        test_reset;
        test_stream("sub_select", 1'b0, 0, 1'b0, 0, 1'b0);
        test_stream("a_select", 1'b1, 0, 1'b0, 0, 1'b0);
        test_stream("backpressure", 1'b0, 1, 1'b0, 0, 1'b0);
        test_stream("random", 1'($urandom_range(0, 1)), 2, 1'b1, 0, 1'b0);
        test_stream("random_a", 1'b1, 2, 1'b1, 0, 1'b0);
        test_overflow;
        test_rst_mid;
`ifdef IDDMM_DRAIN_FLUSH_EN
        test_flush;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
